// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer for the MIPS PC register: picks the next PC, runs the
// imem request/ack handshake, holds on stalls and defers redirects during waits.
module pc_seq_ctrl #(
  parameter logic [31:0] EXC_VEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        fetch_valid,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  input  logic        eret,
  output logic [31:0] epc,
  output logic [1:0]  state_dbg
);

  // Handshake: imem_req is held while in FETCH; a fetch completes on the
  // rising edge where imem_req and imem_ack are both high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]  pend_pri_q, pend_pri_d;
  logic [31:0] epc_q;

  logic        redir;
  logic [1:0]  redir_pri;
  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;
  logic [31:0] nxt;

  assign pc_inc = pc_cur + 32'd4;
  assign redir  = exc | eret | jmp | br_taken;

  // Priority rank lets a deferred redirect be displaced only by a stronger one.
  always_comb begin
    redir_pri = 2'd0;
    redir_tgt = br_target;
    if (exc) begin
      redir_pri = 2'd3;
      redir_tgt = EXC_VEC;
    end else if (eret) begin
      redir_pri = 2'd2;
      redir_tgt = epc_q;
    end else if (jmp) begin
      redir_pri = 2'd1;
      redir_tgt = jmp_target;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    pend_pri_d  = pend_pri_q;
    pc_ena      = 1'b0;
    nxt         = 32'd0;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (pend_vld_q) begin
            pc_ena     = 1'b1;
            nxt        = pend_tgt_q;
            pend_vld_d = 1'b0;
          end else if (redir) begin
            pc_ena = 1'b1;
            nxt    = redir_tgt;
          end else if (stall) begin
            state_d = HOLD;
          end else begin
            fetch_valid = 1'b1;
            pc_ena      = 1'b1;
            nxt         = pc_inc;
          end
        end else if (redir && (!pend_vld_q || redir_pri > pend_pri_q)) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = redir_tgt;
          pend_pri_d = redir_pri;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_ena  = 1'b1;
          nxt     = redir_tgt;
          state_d = FETCH;
        end else if (!stall) begin
          fetch_valid = 1'b1;
          pc_ena      = 1'b1;
          nxt         = pc_inc;
          state_d     = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'd0;
      pend_pri_q <= 2'd0;
      epc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      pend_pri_q <= pend_pri_d;
      if (exc) epc_q <= pc_cur;
    end
  end

  assign pc_next   = nxt & ~32'd3;
  assign epc       = epc_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: owns the PC register, drives directed and random
// traffic and compares the sequencer against a behavioural reference.
module tb_pc_seq_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur = 32'd0;
  logic        pc_ena, imem_req, fetch_valid;
  logic [31:0] pc_next, epc;
  logic [1:0]  state_dbg;
  logic        imem_ack = 1'b0, stall = 1'b0;
  logic        br_taken = 1'b0, jmp = 1'b0, exc = 1'b0, eret = 1'b0;
  logic [31:0] br_target = 32'd0, jmp_target = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset block
  always #5 clk = ~clk;

  pc_seq_ctrl #(.EXC_VEC(EXC_VEC)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_ena(pc_ena), .pc_next(pc_next),
    .imem_req(imem_req), .imem_ack(imem_ack), .fetch_valid(fetch_valid),
    .stall(stall), .br_taken(br_taken), .br_target(br_target), .jmp(jmp),
    .jmp_target(jmp_target), .exc(exc), .eret(eret), .epc(epc),
    .state_dbg(state_dbg)
  );

  // reference model: started / holding flags, a deferred-redirect slot, epc, PC
  bit          m_run, m_hold, m_pend;
  logic [31:0] m_pend_tgt, m_epc, m_pc;
  int          m_pend_rank;
  bit          n_run, n_hold, n_pend;
  logic [31:0] n_pend_tgt;
  int          n_pend_rank;
  bit          e_ena, e_req, e_fv;
  logic [31:0] e_next;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_hold = 0; m_pend = 0; m_pend_tgt = 0; m_pend_rank = 0;
    m_epc = 0; m_pc = 0; pc_cur = 32'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 0; stall = 0; br_taken = 0; jmp = 0; exc = 0; eret = 0;
    #1;
    model_reset();
    check("rst_ena", pc_ena, 0);
    check("rst_next", pc_next, 0);
    check("rst_req", imem_req, 0);
    check("rst_fv", fetch_valid, 0);
    check("rst_epc", epc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    m_pc = v;
    pc_cur = v;
  endtask

  // driver: apply one cycle of inputs, predict and compare combinational outputs
  task automatic cyc_begin(input bit ack, input bit stl, input bit br, input logic [31:0] brt,
                           input bit j, input logic [31:0] jt, input bit ex, input bit er);
    int          rank;
    bit          any;
    logic [31:0] tgt;
    @(negedge clk);
    imem_ack = ack; stall = stl; br_taken = br; br_target = brt;
    jmp = j; jmp_target = jt; exc = ex; eret = er;
    #1;
    any  = ex | er | j | br;
    rank = ex ? 3 : er ? 2 : j ? 1 : 0;
    tgt  = ex ? EXC_VEC : er ? m_epc : j ? jt : brt;
    e_ena = 0; e_req = 0; e_fv = 0; e_next = 0;
    n_run = 1; n_hold = m_hold; n_pend = m_pend; n_pend_tgt = m_pend_tgt;
    n_pend_rank = m_pend_rank;
    if (!m_run) begin
      n_hold = 0;
    end else if (!m_hold) begin
      e_req = 1;
      if (ack) begin
        if (m_pend) begin
          e_ena = 1; e_next = m_pend_tgt; n_pend = 0;
        end else if (any) begin
          e_ena = 1; e_next = tgt;
        end else if (stl) begin
          n_hold = 1;
        end else begin
          e_fv = 1; e_ena = 1; e_next = m_pc + 32'd4;
        end
      end else if (any && (!m_pend || rank > m_pend_rank)) begin
        n_pend = 1; n_pend_tgt = tgt; n_pend_rank = rank;
      end
    end else begin
      if (any) begin
        e_ena = 1; e_next = tgt; n_hold = 0;
      end else if (!stl) begin
        e_fv = 1; e_ena = 1; e_next = m_pc + 32'd4; n_hold = 0;
      end
    end
    e_next = e_next & 32'hFFFF_FFFC;
    exp_q.push_back(ex ? m_pc : m_epc);
    check("imem_req", imem_req, e_req);
    check("pc_ena", pc_ena, e_ena);
    check("fetch_valid", fetch_valid, e_fv);
    if (e_ena) check("pc_next", pc_next, e_next);
  endtask

  // clock edge: commit the model, load the PC register, score epc
  task automatic cyc_end();
    logic [31:0] exp_epc;
    @(posedge clk);
    #1;
    m_run = n_run; m_hold = n_hold; m_pend = n_pend;
    m_pend_tgt = n_pend_tgt; m_pend_rank = n_pend_rank;
    if (e_ena) m_pc = e_next;
    pc_cur = m_pc;
    if (exp_q.size() > 0) begin
      exp_epc = exp_q.pop_front();
      m_epc = exp_epc;
      check("epc", epc, exp_epc);
    end else begin
      check("epc_queue", 32'(exp_q.size()), 32'd1);
    end
  endtask

  task automatic cyc(input bit ack, input bit stl, input bit br, input logic [31:0] brt,
                     input bit j, input logic [31:0] jt, input bit ex, input bit er);
    cyc_begin(ack, stl, br, brt, j, jt, ex, er);
    cyc_end();
  endtask

  initial begin
    do_reset();

    // first cycle after reset is idle, then sequential fetch 0,4,8,12
    cyc_begin(1, 0, 0, 0, 0, 0, 0, 0);
    check("idle_req", imem_req, 0);
    cyc_end();
    for (int i = 0; i < 4; i++) begin
      cyc_begin(1, 0, 0, 0, 0, 0, 0, 0);
      check("seq_req", imem_req, 1);
      check("seq_fv", fetch_valid, 1);
      check("seq_next", pc_next, 32'(4 * (i + 1)));
      cyc_end();
    end

    // branch with ack, misaligned target
    set_pc(32'h10);
    cyc_begin(1, 0, 1, 32'h103, 0, 0, 0, 0);
    check("br_ena", pc_ena, 1);
    check("br_next", pc_next, 32'h100);
    check("br_fv", fetch_valid, 0);
    cyc_end();

    // jump during a 3-cycle wait is applied on the ack edge
    set_pc(32'h8);
    cyc_begin(0, 0, 0, 0, 1, 32'h40, 0, 0);
    check("wait_ena0", pc_ena, 0);
    cyc_end();
    for (int i = 0; i < 2; i++) begin
      cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
      check("wait_ena", pc_ena, 0);
      cyc_end();
    end
    cyc_begin(1, 0, 0, 0, 0, 0, 0, 0);
    check("pend_next", pc_next, 32'h40);
    check("pend_fv", fetch_valid, 0);
    cyc_end();

    // stall on ack, hold four cycles, then release
    set_pc(32'd20);
    cyc_begin(1, 1, 0, 0, 0, 0, 0, 0);
    check("stall_ena", pc_ena, 0);
    cyc_end();
    for (int i = 0; i < 3; i++) begin
      cyc_begin(0, 1, 0, 0, 0, 0, 0, 0);
      check("hold_req", imem_req, 0);
      check("hold_ena", pc_ena, 0);
      cyc_end();
    end
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
    check("unhold_fv", fetch_valid, 1);
    check("unhold_next", pc_next, 32'd24);
    cyc_end();

    // exc and eret together: exc wins, epc captured; later eret returns
    set_pc(32'h80);
    cyc_begin(1, 0, 0, 0, 0, 0, 1, 1);
    check("exc_next", pc_next, EXC_VEC);
    cyc_end();
    check("exc_epc", epc, 32'h80);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc_begin(1, 0, 0, 0, 0, 0, 0, 1);
    check("eret_next", pc_next, 32'h80);
    cyc_end();

    // wrap at top of address space
    set_pc(32'hFFFF_FFFC);
    cyc_begin(1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_next", pc_next, 32'h0);
    cyc_end();

    // reset while holding
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    do_reset();
    cyc_begin(1, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_req", imem_req, 0);
    cyc_end();

    // eret with epc never written returns to 0
    cyc_begin(1, 0, 0, 0, 0, 0, 0, 1);
    check("eret_cold", pc_next, 32'h0);
    cyc_end();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Fetch sequencer that drives the enable and next-value inputs of the 32-bit PC register in the MIPS CPU. It selects the next PC from sequential, branch, jump, exception and return sources and runs the instruction-memory request/acknowledge handshake. It holds the PC during pipeline stalls and defers redirects that arrive while a fetch is outstanding. It sits between the hazard/branch logic and the PC register.

## Interface
- EXC_VEC, 32'h0000_0004: exception/interrupt handler address.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_cur  in  32  current PC register output.
- pc_ena  out  1  PC register load enable.
- pc_next  out  32  value loaded into the PC register when pc_ena=1.
- imem_req  out  1  instruction fetch request at address pc_cur.
- imem_ack  in  1  instruction memory has returned data for pc_cur.
- fetch_valid  out  1  returned instruction is valid and passes to decode this cycle.
- stall  in  1  hazard unit stall request.
- br_taken  in  1  conditional branch resolved taken; one-cycle pulse.
- br_target  in  32  branch target.
- jmp  in  1  j/jal/jr redirect; one-cycle pulse.
- jmp_target  in  32  jump target.
- exc  in  1  exception/interrupt; one-cycle pulse.
- eret  in  1  return from exception; one-cycle pulse.
- epc  out  32  saved exception PC.

## Operation
- Redirect priority: exc > eret > jmp > br_taken. The winning target is EXC_VEC, epc, jmp_target or br_target. If no redirect is present, the target is pc_cur+4.
- pc_next[1:0] is always forced to 2'b00. pc_cur+4 wraps modulo 2^32, so 32'hFFFF_FFFC goes to 32'h0000_0000.
- On exc, epc is loaded with pc_cur on that edge. It is unchanged otherwise.
- Pending redirect register: pend_vld plus pend_tgt (32 bits).
  - A redirect arriving while in FETCH with imem_ack=0 sets pend_vld and latches the target.
  - A later redirect of higher priority overwrites it. A lower-priority one is ignored.
- States:
  - IDLE:
    - Entered on reset. All outputs are 0.
    - Moves to FETCH after one cycle.
  - FETCH:
    - imem_req=1.
    - If imem_ack=1 and pend_vld=1: fetch_valid=0 (the instruction is discarded), pc_ena=1, pc_next=pend_tgt, pend_vld is cleared, stay in FETCH.
    - Else if imem_ack=1 and a redirect is present in the same cycle: fetch_valid=0, pc_ena=1, pc_next=redirect target, stay in FETCH.
    - Else if imem_ack=1 and stall=1: fetch_valid=0, pc_ena=0, go to HOLD.
    - Else if imem_ack=1: fetch_valid=1, pc_ena=1, pc_next=pc_cur+4.
    - If imem_ack=0: pc_ena=0 and fetch_valid=0.
  - HOLD:
    - imem_req=0. The fetched instruction is held by the decode stage.
    - A redirect in HOLD takes effect at once: pc_ena=1, pc_next=target, go to FETCH.
    - Else if stall=0: fetch_valid=1, pc_ena=1, pc_next=pc_cur+4, go to FETCH.
    - Else: stay in HOLD with pc_ena=0.
- pc_ena, pc_next, imem_req and fetch_valid are combinational from state, pending registers and inputs (Mealy). state, pend_vld, pend_tgt and epc are registered.
- eret while epc was never written returns to 32'h0000_0000.

## Timing
- Reset values: state=IDLE, pend_vld=0, pend_tgt=0, epc=0. This gives pc_ena=0, pc_next=0, imem_req=0, fetch_valid=0.
- Reset asserted mid-fetch aborts the fetch. The pending redirect is dropped, and the PC register resets to 0 in parallel.
- First imem_req is asserted one cycle after rst deasserts, at pc_cur=0.
- Zero-wait memory (imem_ack tied high) gives one fetch per cycle. The PC advances on the same edge that samples imem_ack.
- Redirect latency:
  - Redirect with imem_ack=1 or in HOLD: the new PC is in the register after 1 edge.
  - Redirect during a wait: the new PC is loaded on the ack edge.
- stall and redirect in the same HOLD cycle: the redirect wins.
- exc and eret in the same cycle: exc wins, and epc is written with pc_cur.

## Test plan
- Reset release, imem_ack=1 constantly -> imem_req rises 1 cycle after rst falls; the PC sequence is 0, 4, 8, 12 with fetch_valid=1 each cycle.
- pc_cur=32'h0000_0010, br_taken=1, br_target=32'h0000_0103, imem_ack=1 -> pc_ena=1, pc_next=32'h0000_0100, fetch_valid=0.
- At pc_cur=8: imem_ack low 3 cycles, jmp pulse with jmp_target=32'h40 in cycle 1, then imem_ack=1 -> no pc_ena during the wait; on ack, pc_next=32'h40, fetch_valid=0.
- stall=1 on ack at pc_cur=20 for 4 cycles -> HOLD, pc_ena=0; on stall=0: fetch_valid=1, pc_next=24.
- pc_cur=32'h80, exc and eret both pulsed -> pc_next=EXC_VEC=4, epc=32'h80; later eret -> pc_next=32'h80.
- pc_cur=32'hFFFF_FFFC, imem_ack=1 -> pc_next=0. rst pulsed while in HOLD -> IDLE, all outputs 0.
